// File: rtl/pwm_if.sv
// Sample/gate bundle between the delta-sigma modulator and the PWM output stage.
// The master supplies the run request and duty word; the slave returns the gates and status.
interface pwm_if;
    logic        en;
    logic [15:0] value;
    logic        pwm_hi;
    logic        pwm_lo;
    logic        tick;
    logic        busy;
    logic        sat;

    modport master (
        output en, value,
        input  pwm_hi, pwm_lo, tick, busy, sat
    );

    modport slave (
        input  en, value,
        output pwm_hi, pwm_lo, tick, busy, sat
    );
endinterface

// File: rtl/pwm_out.sv
// Fixed-period PWM stage: one modulator sample per period, complementary gates with dead band.
// tick marks the last clock of every running period and doubles as the modulator's advance enable.
module pwm_out #(
    parameter int PERIOD = 256,
    parameter int DEAD   = 4
) (
    input  logic  clk,
    input  logic  rst,
    pwm_if.slave  bus
);
    localparam int CW = $clog2(PERIOD + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW-1:0] LAST_C   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
    localparam logic [31:0]   PERIOD_W = 32'(PERIOD);

    logic [0:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] duty_reg;
    logic [CW-1:0] dcnt_reg, dcnt_next;
    logic          raw_q_reg;
    logic          sat_reg;
    logic          pwm_hi_reg;
    logic          pwm_lo_reg;

    logic          running;
    logic          run_next;
    logic          is_last;
    logic          entry;
    logic          raw;
    logic          value_over;
    logic [CW-1:0] value_clamped;
    logic          settled;

    assign running  = (state_reg == RUN);
    assign is_last  = running && (cnt_reg == LAST_C);
    assign entry    = (state_reg == IDLE) && bus.en;
    assign raw      = running && (cnt_reg < duty_reg);
    assign settled  = (dcnt_reg == DEAD_C);

    // Compare at full width so oversized words clamp instead of wrapping into CW bits.
    assign value_over    = ({16'd0, bus.value} > PERIOD_W);
    assign value_clamped = value_over ? PERIOD_C : CW'(bus.value);

    always_comb begin
        state_next = state_reg;
        if (state_reg == IDLE) begin
            if (bus.en) state_next = RUN;
        end else if (is_last && !bus.en) begin
            state_next = IDLE;
        end
    end

    assign run_next = (state_next == RUN);

    // Any edge on raw_q (or a fresh start) restarts the dead-band timer.
    always_comb begin
        dcnt_next = dcnt_reg;
        if (entry || (raw != raw_q_reg)) begin
            dcnt_next = '0;
        end else if (!settled) begin
            dcnt_next = dcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            duty_reg   <= '0;
            raw_q_reg  <= 1'b0;
            dcnt_reg   <= DEAD_C;
            sat_reg    <= 1'b0;
            pwm_hi_reg <= 1'b0;
            pwm_lo_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            raw_q_reg <= raw;
            dcnt_reg  <= dcnt_next;

            if (entry) begin
                cnt_reg  <= '0;
                duty_reg <= value_clamped;
                sat_reg  <= value_over;
            end else if (running) begin
                if (is_last) begin
                    cnt_reg <= '0;
                    if (bus.en) begin
                        duty_reg <= value_clamped;
                        sat_reg  <= value_over;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Gating on run_next drops both gates on the same edge that leaves RUN.
            pwm_hi_reg <=  raw_q_reg && settled && running && run_next;
            pwm_lo_reg <= !raw_q_reg && settled && running && run_next;
        end
    end

    assign bus.pwm_hi = pwm_hi_reg;
    assign bus.pwm_lo = pwm_lo_reg;
    assign bus.tick   = is_last;
    assign bus.busy   = running;
    assign bus.sat    = sat_reg;
endmodule

// File: tb/tb_pwm_out.sv
// Directed bench for pwm_out: DUT A (PERIOD=8, DEAD=0) and DUT B (PERIOD=8, DEAD=2).
// Each period is captured as 8-bit vectors indexed by the in-period count.
module tb_pwm_out;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_b = 1'b0;

    int checks   = 0;
    int failures = 0;

    pwm_if ifa ();
    pwm_if ifb ();

    pwm_out #(.PERIOD(8), .DEAD(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pwm_out #(.PERIOD(8), .DEAD(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    logic mon_hi, mon_lo, mon_tick, mon_busy, mon_sat;
    assign mon_hi   = sel_b ? ifb.pwm_hi : ifa.pwm_hi;
    assign mon_lo   = sel_b ? ifb.pwm_lo : ifa.pwm_lo;
    assign mon_tick = sel_b ? ifb.tick   : ifa.tick;
    assign mon_busy = sel_b ? ifb.busy   : ifa.busy;
    assign mon_sat  = sel_b ? ifb.sat    : ifa.sat;

    logic [7:0] r_hi, r_lo, r_tk, r_bs, r_st;

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mon_tick && n < 40);
        checks++;
        if (mon_tick !== 1'b1) begin
            failures++;
            $display("FAIL %s tick_timeout got=%b want=1", name, mon_tick);
        end
    endtask

    // Capture the 8 cycles that follow a tick cycle: index c is cnt==c.
    task automatic record_period(input string name);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r_hi[c] = mon_hi; r_lo[c] = mon_lo; r_tk[c] = mon_tick;
            r_bs[c] = mon_busy; r_st[c] = mon_sat;
        end
        $display("period %s hi=%b lo=%b tick=%b busy=%b sat=%b", name, r_hi, r_lo, r_tk, r_bs, r_st);
    endtask

    task automatic test_reset();
        ifa.en = 1'b0; ifa.value = 16'd0;
        ifb.en = 1'b0; ifb.value = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.pwm_hi, ifa.pwm_lo, ifa.tick, ifa.busy, ifa.sat} !== 5'b0) begin
            failures++;
            $display("FAIL reset_a got=%b want=00000", {ifa.pwm_hi, ifa.pwm_lo, ifa.tick, ifa.busy, ifa.sat});
        end
        checks++;
        if ({ifb.pwm_hi, ifb.pwm_lo, ifb.tick, ifb.busy, ifb.sat} !== 5'b0) begin
            failures++;
            $display("FAIL reset_b got=%b want=00000", {ifb.pwm_hi, ifb.pwm_lo, ifb.tick, ifb.busy, ifb.sat});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.pwm_hi, ifa.pwm_lo, ifa.tick, ifa.busy} !== 4'b0) begin
            failures++;
            $display("FAIL idle_no_en got=%b want=0000", {ifa.pwm_hi, ifa.pwm_lo, ifa.tick, ifa.busy});
        end
    endtask

    task automatic test_basic();
        sel_b = 1'b0;
        ifa.value = 16'd3; ifa.en = 1'b1;
        wait_tick("basic"); wait_tick("basic");
        record_period("basic");
        checks++;
        if (r_hi !== 8'b0001_1100) begin failures++; $display("FAIL basic_hi got=%b want=00011100", r_hi); end
        checks++;
        if (r_lo !== 8'b1110_0011) begin failures++; $display("FAIL basic_lo got=%b want=11100011", r_lo); end
        checks++;
        if (r_tk !== 8'b1000_0000) begin failures++; $display("FAIL basic_tick got=%b want=10000000", r_tk); end
        checks++;
        if ({r_bs, r_st} !== 16'hFF00) begin failures++; $display("FAIL basic_busy_sat got=%h want=ff00", {r_bs, r_st}); end
    endtask

    task automatic test_dead_band();
        sel_b = 1'b1;
        ifb.value = 16'd4; ifb.en = 1'b1;
        wait_tick("dead4"); wait_tick("dead4");
        record_period("dead4");
        checks++;
        if (r_hi !== 8'b0011_0000) begin failures++; $display("FAIL dead4_hi got=%b want=00110000", r_hi); end
        checks++;
        if (r_lo !== 8'b0000_0011) begin failures++; $display("FAIL dead4_lo got=%b want=00000011", r_lo); end
        checks++;
        if ((r_hi & r_lo) !== 8'h00) begin failures++; $display("FAIL dead4_overlap got=%b want=00000000", r_hi & r_lo); end
        // A 2-clock high pulse is no longer than the dead band and must vanish.
        ifb.value = 16'd2;
        wait_tick("dead2"); wait_tick("dead2");
        record_period("dead2");
        checks++;
        if (r_hi !== 8'h00) begin failures++; $display("FAIL dead2_hi got=%b want=00000000", r_hi); end
        checks++;
        if (r_lo !== 8'b1100_0011) begin failures++; $display("FAIL dead2_lo got=%b want=11000011", r_lo); end
        ifb.en = 1'b0;
        repeat (12) @(negedge clk);
        sel_b = 1'b0;
    endtask

    task automatic test_boundaries();
        ifa.value = 16'd0;
        wait_tick("duty0"); wait_tick("duty0");
        record_period("duty0");
        checks++;
        if ({r_hi, r_lo, r_st} !== 24'h00FF00) begin failures++; $display("FAIL duty0 got=%h want=00ff00", {r_hi, r_lo, r_st}); end
        ifa.value = 16'd8;
        wait_tick("duty8"); wait_tick("duty8");
        record_period("duty8");
        checks++;
        if ({r_hi, r_lo, r_st} !== 24'hFF0000) begin failures++; $display("FAIL duty8 got=%h want=ff0000", {r_hi, r_lo, r_st}); end
        checks++;
        if (r_tk !== 8'b1000_0000) begin failures++; $display("FAIL duty8_tick got=%b want=10000000", r_tk); end
        ifa.value = 16'd20;
        wait_tick("duty20"); wait_tick("duty20");
        record_period("duty20");
        checks++;
        if ({r_hi, r_lo, r_st} !== 24'hFF00FF) begin failures++; $display("FAIL duty20 got=%h want=ff00ff", {r_hi, r_lo, r_st}); end
    endtask

    task automatic test_mid_period_value();
        ifa.value = 16'd3;
        wait_tick("midval"); wait_tick("midval");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r_hi[c] = mon_hi;
            if (c == 4) ifa.value = 16'd6;
        end
        $display("period midval_p1 hi=%b", r_hi);
        checks++;
        if (r_hi !== 8'b0001_1100) begin failures++; $display("FAIL midval_p1_hi got=%b want=00011100", r_hi); end
        record_period("midval_p2");
        checks++;
        if ({r_hi, r_lo} !== 16'b1111_1100_0000_0011) begin failures++; $display("FAIL midval_p2 got=%b want=1111110000000011", {r_hi, r_lo}); end
        record_period("midval_p3");
        checks++;
        if (r_hi !== 8'b1111_1100) begin failures++; $display("FAIL midval_p3_hi got=%b want=11111100", r_hi); end
    endtask

    task automatic test_en_drop();
        ifa.value = 16'd3;
        wait_tick("endrop"); wait_tick("endrop");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r_hi[c] = mon_hi; r_tk[c] = mon_tick; r_bs[c] = mon_busy;
            if (c == 2) ifa.en = 1'b0;
        end
        $display("period endrop hi=%b tick=%b busy=%b", r_hi, r_tk, r_bs);
        checks++;
        if ({r_hi, r_tk, r_bs} !== 24'b0001_1100_1000_0000_1111_1111) begin
            failures++;
            $display("FAIL endrop_period got=%b want=000111001000000011111111", {r_hi, r_tk, r_bs});
        end
        @(negedge clk);
        checks++;
        if ({mon_hi, mon_lo, mon_tick, mon_busy} !== 4'b0) begin
            failures++;
            $display("FAIL endrop_idle got=%b want=0000", {mon_hi, mon_lo, mon_tick, mon_busy});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({mon_hi, mon_lo, mon_busy} !== 3'b0) begin
            failures++;
            $display("FAIL endrop_stay got=%b want=000", {mon_hi, mon_lo, mon_busy});
        end
    endtask

    task automatic test_reset_mid();
        ifa.value = 16'd3; ifa.en = 1'b1;
        wait_tick("rstmid"); wait_tick("rstmid");
        repeat (6) @(negedge clk);
        checks++;
        if ({mon_lo, mon_busy} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b want=11", {mon_lo, mon_busy}); end
        rst = 1'b1;
        #1;
        checks++;
        if ({mon_hi, mon_lo, mon_tick, mon_busy, mon_sat} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_async got=%b want=00000", {mon_hi, mon_lo, mon_tick, mon_busy, mon_sat});
        end
        @(negedge clk);
        rst = 1'b0;
        record_period("restart");
        checks++;
        if ({r_hi, r_lo} !== 16'b0001_1100_1110_0010) begin failures++; $display("FAIL restart_gates got=%b want=0001110011100010", {r_hi, r_lo}); end
        checks++;
        if ({r_tk, r_bs} !== 16'b1000_0000_1111_1111) begin failures++; $display("FAIL restart_tick_busy got=%b want=1000000011111111", {r_tk, r_bs}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dead_band();
        test_boundaries();
        test_mid_period_value();
        test_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
